// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES-128 round controller family.
//   - ctrl_state_e : controller FSM states
//   - AES_BLOCK_W, AES128_ROUNDS : block width and round count
//   - RCON / rcon_of() : key-schedule round constants, rounds 1..10
//   - aes_sbox() : AES S-box, computed as GF(2^8) inverse plus affine map
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES128_ROUNDS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDKEY,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } ctrl_state_e;

    // Index 10 is the leftmost byte, index 1 the rightmost.
    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    // Out-of-range round numbers map to 0 so a speculative lookup past the
    // last round stays defined.
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        if (rnd >= 4'd1 && rnd <= 4'd10) r = RCON[rnd];
        return r;
    endfunction

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (x^2 * x^4 * ... * x^128); 0 maps to 0 naturally.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step (combinational).
//   key_i  [127:0] current round key
//   rcon_i [7:0]   round constant for the key being produced
//   key_o  [127:0] next round key
module aes_key_step
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] key_i,
    input  logic [7:0]             rcon_i,
    output logic [AES_BLOCK_W-1:0] key_o
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub, t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_i;

    // RotWord then SubWord on the last word, then fold in rcon.
    assign rot = {w3[23:0], w3[31:24]};
    assign sub = {aes_sbox(rot[31:24]), aes_sbox(rot[23:16]),
                  aes_sbox(rot[15:8]),  aes_sbox(rot[7:0])};
    assign t   = sub ^ {rcon_i, 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign key_o = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences a single-round AES datapath through AES-128
// encryption (initial AddRoundKey, 9 full rounds, 1 final round) and derives
// each round key on the fly.
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         plaintext + key handshake (in_data, in_key)
//   out_valid/out_ready       ciphertext handshake (out_data)
//   busy                      high whenever not idle
//   rd_start_o                one-cycle start pulse to the round datapath
//   rd_data_o/rd_key_o        state and round key for the datapath
//   rd_final_o                final round (datapath skips MixColumns)
//   rd_data_i/rd_ready_i      datapath result, qualified by a 1-cycle pulse
//   err_o                     sticky watchdog flag (AES_CTRL_TIMEOUT_EN only)
// Optional: define AES_CTRL_TIMEOUT_EN to add a per-round watchdog of
// TIMEOUT_CYCLES cycles; without it WAIT waits indefinitely.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
`ifdef AES_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic [AES_BLOCK_W-1:0] in_key,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy,
    output logic                   rd_start_o,
    output logic [AES_BLOCK_W-1:0] rd_data_o,
    output logic [AES_BLOCK_W-1:0] rd_key_o,
    output logic                   rd_final_o,
    input  logic [AES_BLOCK_W-1:0] rd_data_i,
    input  logic                   rd_ready_i
`ifdef AES_CTRL_TIMEOUT_EN
    , output logic                 err_o
`endif
);
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    ctrl_state_e            state_q, state_d;
    logic [3:0]             rnd_q, rnd_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d;
    logic [AES_BLOCK_W-1:0] key_q, key_d;
    logic                   rd_start_q, rd_start_d;
    logic [AES_BLOCK_W-1:0] rd_data_q, rd_data_d;
    logic [AES_BLOCK_W-1:0] rd_key_q, rd_key_d;
    logic                   rd_final_q, rd_final_d;
    logic [AES_BLOCK_W-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;

    logic [AES_BLOCK_W-1:0] ks_key_in, ks_key_out;
    logic [3:0]             next_rnd;
    logic [7:0]             rcon_sel;

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          err_q, err_d;
    assign err_o = err_q;
`endif

    // The next round's key is computed one step ahead so that rd_key_o is
    // already registered when the start pulse goes out. From ADDKEY the source
    // is round key 0; from WAIT it is the key of the round just finished.
    assign ks_key_in = (state_q == ST_ADDKEY) ? key_q : rd_key_q;
    assign next_rnd  = (state_q == ST_ADDKEY) ? 4'd1 : rnd_q + 4'd1;
    assign rcon_sel  = rcon_of(next_rnd);

    aes_key_step u_key_step (
        .key_i  (ks_key_in),
        .rcon_i (rcon_sel),
        .key_o  (ks_key_out)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        data_d      = data_q;
        key_d       = key_q;
        rd_start_d  = rd_start_q;
        rd_data_d   = rd_data_q;
        rd_key_d    = rd_key_q;
        rd_final_d  = rd_final_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef AES_CTRL_TIMEOUT_EN
        wcnt_d      = wcnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    key_d   = in_key;
                    state_d = ST_ADDKEY;
`ifdef AES_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_ADDKEY: begin
                data_d     = data_q ^ key_q;
                rnd_d      = 4'd1;
                rd_start_d = 1'b1;
                rd_data_d  = data_q ^ key_q;
                rd_key_d   = ks_key_out;
                rd_final_d = (next_rnd == LAST_RND);
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                // rd_ready_i is deliberately not looked at here.
                rd_start_d = 1'b0;
                state_d    = ST_WAIT;
`ifdef AES_CTRL_TIMEOUT_EN
                wcnt_d     = '0;
`endif
            end
            ST_WAIT: begin
                if (rd_ready_i) begin
                    data_d = rd_data_i;
                    key_d  = rd_key_q;
                    if (rnd_q == LAST_RND) begin
                        out_data_d  = rd_data_i;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        rnd_d      = next_rnd;
                        rd_start_d = 1'b1;
                        rd_data_d  = rd_data_i;
                        rd_key_d   = ks_key_out;
                        rd_final_d = (next_rnd == LAST_RND);
                        state_d    = ST_ISSUE;
                    end
                end
`ifdef AES_CTRL_TIMEOUT_EN
                else if (wcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            data_q      <= '0;
            key_q       <= '0;
            rd_start_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_key_q    <= '0;
            rd_final_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
            wcnt_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            data_q      <= data_d;
            key_q       <= key_d;
            rd_start_q  <= rd_start_d;
            rd_data_q   <= rd_data_d;
            rd_key_q    <= rd_key_d;
            rd_final_q  <= rd_final_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef AES_CTRL_TIMEOUT_EN
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rd_start_o = rd_start_q;
    assign rd_data_o  = rd_data_q;
    assign rd_key_o   = rd_key_q;
    assign rd_final_o = rd_final_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Sequences the single-round AES datapath (`round`) through a full AES-128 encryption: initial AddRoundKey, 9 full rounds, 1 final round.
- Generates each round key on the fly, one key-schedule step per round.
- Block-level valid/ready handshakes on the input and output sides; round-datapath handshake is start pulse / ready pulse.
- Sits between the top-level crypto wrapper and the `round` instance.

Parameters:
- NUM_ROUNDS, 10, rounds after the initial AddRoundKey (AES-128 only; other values unsupported).
- TIMEOUT_CYCLES, 64, watchdog limit per round; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext/key offered.
- in_ready  out  1  controller idle and accepting.
- in_data  in  128  plaintext block.
- in_key  in  128  cipher key.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  128  ciphertext.
- busy  out  1  high in every state except IDLE.
- rd_start_o  out  1  one-cycle start pulse to the round datapath.
- rd_data_o  out  128  state to the round datapath.
- rd_key_o  out  128  round key to the round datapath.
- rd_final_o  out  1  final round, no MixColumns (maps to `round` input).
- rd_data_i  in  128  round datapath result.
- rd_ready_i  in  1  one-cycle pulse qualifying rd_data_i.
- err_o  out  1  timeout flag; present only with AES_CTRL_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, round counter=0.
  - All rd_* outputs, out_data, out_valid, busy, err_o = 0.
  - in_ready=1 once state is IDLE.
- FSM states: IDLE, ADDKEY, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready latches in_data and in_key into registers -> ADDKEY.
- ADDKEY (1 cycle):
  - state_reg = data ^ key.
  - key_reg = key (round key 0).
  - rnd = 1 -> ISSUE.
- ISSUE (1 cycle):
  - rd_start_o=1.
  - rd_data_o=state_reg.
  - rd_key_o = key_step(key_reg, rcon[rnd]).
  - rd_final_o = (rnd==NUM_ROUNDS).
  - -> WAIT.
- WAIT:
  - rd_data_o, rd_key_o and rd_final_o are registered and held stable until rd_ready_i is sampled.
  - On rd_ready_i: state_reg=rd_data_i, key_reg=rd_key_o.
  - If rnd==NUM_ROUNDS: out_data=rd_data_i -> DONE. Otherwise rnd+1 -> ISSUE.
- DONE:
  - out_valid=1 and out_data held until out_valid&out_ready.
  - Then out_valid=0 -> IDLE.
  - in_ready=0 in DONE; no same-cycle turnaround.
- rcon table: 01,02,04,08,10,20,40,80,1b,36 for rnd 1..10.
- rd_ready_i outside WAIT is ignored. rd_ready_i in the same cycle as rd_start_o is ignored.
- in_valid while busy is ignored; in_data and in_key are not re-sampled.
- Latency: with the datapath answering L cycles after sampling start, out_valid rises 1+10*(1+L) rising edges after the accept edge. For L=1 that is 21.
- Reset mid-operation: aborts immediately. A late rd_ready_i after reset is ignored (state is IDLE).

Optional Feature:
- Macro: AES_CTRL_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT and clears on each ISSUE.
  - Reaching TIMEOUT_CYCLES without rd_ready_i sets err_o=1 (sticky) and the FSM goes to IDLE without asserting out_valid.
  - err_o clears on the next accepted input or on rst.
- When undefined: no counter, no err_o port; WAIT waits indefinitely.

Decomposition:
- Package aes_pkg holds:
  - FSM state enum.
  - AES_BLOCK_W=128 and AES128_ROUNDS=10 constants.
  - rcon constant array.
  - S-box function.
- Sub-module aes_key_step (combinational): 128-bit key plus 8-bit rcon in, next round key out (RotWord/SubWord/XOR chain). Reused by the decryption controller later.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, behavioural round stub L=1 -> first ISSUE rd_key_o=d6aa74fdd2af72fadaa678f1d6ab76fe; out_data=69c4e0d86a7b0430d8cdb78070b4c55a exactly 21 edges after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; rd_final_o high only in round 10; exactly 10 rd_start_o pulses.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stable; in_ready=0 throughout; in_valid pulses in that window are not accepted.
- Variable latency: stub L randomised 1..7 per round, spurious rd_ready_i in IDLE/ISSUE -> ciphertext unchanged; rd_* outputs stable during every WAIT.
- Reset mid-operation: assert rst during WAIT of round 5 -> all outputs 0 asynchronously, in_ready=1 after release; next block encrypts correctly.
- With AES_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=64: stub never answers -> err_o=1 after 64 WAIT cycles, state IDLE, out_valid never asserted; next accepted block clears err_o.
